// File: rtl/crc_lut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_lut_pkg
//  Description : Shared types, table geometry and the rotating-priority pick
//                function used by the CRC lookup-table scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_lut_pkg;

    localparam int CRC_TAB_AW = 8;
    localparam int CRC_TAB_DW = 32;

    // Largest requester count the pick function handles natively
    localparam int RR_MAX_N = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Rotating priority search starting at ptr. The scan wraps at RR_MAX_N;
    // callers zero every bit at or above their own requester count, so the
    // visiting order is identical to a wrap at that count.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                         input logic [2:0]          ptr);
        rr_pick_t   r;
        logic [2:0] j;
        r = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            j = ptr + 3'(k);
            if (!r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lut_sched_rr_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_prio_sel
//  Description : Rotating priority encoder. Grants the first active request
//                at or after the pointer, wrapping at NREQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_sel
    import crc_lut_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_found
);

    logic [RR_MAX_N-1:0] w_req8;
    logic [2:0]          w_ptr3;
    rr_pick_t            w_pick;
    logic                w_unused;

    // Widen request and pointer to the fixed width of the pick function
    always_comb begin
        w_req8             = '0;
        w_req8[NREQ-1:0]   = i_req;
        w_ptr3             = '0;
        w_ptr3[IDW-1:0]    = i_ptr;
        w_pick             = rr_pick(w_req8, w_ptr3);
    end

    // Index bits above IDW are always zero for NREQ < 8
    assign w_unused = &{1'b0, w_pick.idx};

    // Narrow the result back and form the one-hot grant
    always_comb begin
        o_found = w_pick.found;
        o_idx   = w_pick.idx[IDW-1:0];
        o_gnt   = '0;
        if (w_pick.found) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_lut_sched.sv
`default_nettype none
// ============================================================================
//  Module      : crc_lut_sched
//  Description : Round-robin scheduler sharing one 256x32 CRC lookup table
//                among NREQ byte-wise CRC engines, with locked bursts and a
//                registered, ID-tagged response one cycle after each grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_lut_sched
    import crc_lut_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*8-1:0]     req_index,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [31:0]           tab_addr,
    input  logic [CRC_TAB_DW-1:0] tab_rdata,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [CRC_TAB_DW-1:0] rsp_data,
    output logic [IDW-1:0]        rsp_id
);

    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

    sched_state_t          r_state;
    logic [IDW-1:0]        r_owner;
    logic [IDW-1:0]        r_rr_ptr;
    logic [NREQ-1:0]       r_rsp_valid;
    logic [CRC_TAB_DW-1:0] r_rsp_data;
    logic [IDW-1:0]        r_rsp_id;

    logic [NREQ-1:0]       w_sel_gnt;
    logic [IDW-1:0]        w_sel_idx;
    logic                  w_sel_found;

    logic [NREQ-1:0]       w_gnt;
    logic [IDW-1:0]        w_gnt_idx;
    logic                  w_xfer;
    logic [CRC_TAB_AW-1:0] w_index;
    logic                  w_last;
    logic [IDW-1:0]        w_next_ptr;

    rr_prio_sel #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_sel (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_sel_gnt),
        .o_idx   (w_sel_idx),
        .o_found (w_sel_found)
    );

    // Grant selection: round-robin when idle, owner-only while locked.
    // A grant is issued only to a valid requester, so a grant is a transfer.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_xfer    = 1'b0;
        if (r_state == IDLE) begin
            w_gnt     = w_sel_gnt;
            w_gnt_idx = w_sel_idx;
            w_xfer    = w_sel_found;
        end else if (req_valid[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            w_gnt_idx      = r_owner;
            w_xfer         = 1'b1;
        end
    end

    // Mux the granted requester's index and last flag; zero when no grant
    always_comb begin
        w_index = '0;
        w_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_index = req_index[i*8 +: 8];
                w_last  = req_last[i];
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + 1'b1;

    assign req_ready = w_gnt;
    assign tab_addr  = {{(32-CRC_TAB_AW){1'b0}}, w_index};

    // Scheduler FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_gnt;
            if (w_xfer) begin
                r_rsp_data <= tab_rdata;
                r_rsp_id   <= w_gnt_idx;
            end
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_rr_ptr <= w_next_ptr;
                        if (!w_last) begin
                            r_owner <= w_gnt_idx;
                            r_state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_xfer && w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire
